// File: rtl/norm_stats_pkg.sv
// Shared constants, widths and FSM encoding for the norm statistics producer.
package norm_stats_pkg;

    localparam int unsigned DWIDTH      = 8;
    localparam int unsigned DESIGN_SIZE = 32;
    localparam int unsigned MASK_WIDTH  = 32;
    localparam int unsigned MAX_ROWS    = 16;
    localparam int unsigned ROWS_W      = $clog2(MAX_ROWS + 1);

    localparam int unsigned SUM_W = 18;
    localparam int unsigned SQ_W  = 24;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = 24;
    localparam int unsigned VAR_W = 15;
    localparam int unsigned Y_W   = 7;

    localparam int unsigned       RSQRT_NUM = 4096;
    localparam logic [DWIDTH-1:0] INV_SAT   = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DIV_MEAN,
        ST_DIV_SQ,
        ST_VAR,
        ST_RSQRT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/norm_stats_if.sv
// Row stream in, statistics out; master drives rows, slave is the statistics block.
interface norm_stats_if;
    import norm_stats_pkg::*;

    logic                          enable_stats;
    logic [ROWS_W-1:0]             num_rows;
    logic                          in_data_available;
    logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]         validity_mask;
    logic [DWIDTH-1:0]             mean;
    logic [DWIDTH-1:0]             inv_var;
    logic                          stats_valid;
    logic                          done_stats;
    logic                          busy;

    modport master (
        output enable_stats, num_rows, in_data_available, inp_data, validity_mask,
        input  mean, inv_var, stats_valid, done_stats, busy
    );

    modport slave (
        input  enable_stats, num_rows, in_data_available, inp_data, validity_mask,
        output mean, inv_var, stats_valid, done_stats, busy
    );

endinterface

// File: rtl/norm_stats_div.sv
// Serial restoring unsigned divider, 24b / 10b, one quotient bit per cycle.
// The start cycle already resolves the top quotient bit; done pulses once DIV_W bits are in.
module norm_stats_div
    import norm_stats_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic [DIV_W-1:0] quotient_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned BIT_W = $clog2(DIV_W);

    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic [BIT_W-1:0] bits_q, bits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] step_rem_in;
    logic [CNT_W-1:0] step_den;
    logic             step_bit;
    logic [CNT_W:0]   trial;
    logic [CNT_W-1:0] step_rem_out;
    logic             step_q;

    always_comb begin
        step_rem_in  = start_i ? '0 : rem_q;
        step_bit     = start_i ? dividend_i[DIV_W-1] : quo_q[DIV_W-1];
        step_den     = start_i ? divisor_i : den_q;
        trial        = {step_rem_in, step_bit};
        step_q       = 1'b0;
        step_rem_out = trial[CNT_W-1:0];
        if (trial >= {1'b0, step_den}) begin
            step_q       = 1'b1;
            step_rem_out = CNT_W'(trial - {1'b0, step_den});
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        bits_d = bits_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            rem_d  = step_rem_out;
            quo_d  = {dividend_i[DIV_W-2:0], step_q};
            den_d  = divisor_i;
            bits_d = BIT_W'(DIV_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = step_rem_out;
            quo_d  = {quo_q[DIV_W-2:0], step_q};
            bits_d = bits_q - BIT_W'(1);
            if (bits_q == BIT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            bits_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            bits_q <= bits_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient_o = quo_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: rtl/norm_stats.sv
// Accumulates masked row sums/sum-of-squares, then derives Q5.3 mean and 1/sqrt(variance)
// for the downstream norm stage.
module norm_stats
    import norm_stats_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    norm_stats_if.slave bus
);
    state_e                  state_q, state_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [SQ_W-1:0]         sumsq_q, sumsq_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROWS_W-1:0]       rows_q, rows_d;
    logic [ROWS_W-1:0]       nrows_q, nrows_d;
    logic [DWIDTH-1:0]       mean_w_q, mean_w_d;
    logic [SQ_W-1:0]         ex2_q, ex2_d;
    logic [VAR_W-1:0]        var_q, var_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [2:0]              bit_q, bit_d;
    logic [DWIDTH-1:0]       mean_q, mean_d;
    logic [DWIDTH-1:0]       inv_q, inv_d;
    logic                    valid_q, done_q, busy_q;

    // Per-row masked contributions
    logic signed [DWIDTH-1:0]   lane;
    logic signed [2*DWIDTH-1:0] lane_sq;
    logic signed [SUM_W-1:0]    row_sum;
    logic [SQ_W-1:0]            row_sq;
    logic [CNT_W-1:0]           row_cnt;

    // Divider and post-processing datapath
    logic                      div_start, div_abort, div_busy, div_done;
    logic [DIV_W-1:0]          div_dividend, div_quo;
    logic [SUM_W-1:0]          sum_mag;
    logic [DIV_W-1:0]          mean_div;
    logic [DWIDTH-1:0]         mean_mag, mean_new;
    logic signed [2*DWIDTH-1:0] mean_sq;
    logic signed [SQ_W:0]      var_diff;
    logic [VAR_W-1:0]          var_clamped;
    logic [Y_W-1:0]            trial_y;
    logic [2*Y_W-1:0]          trial_sq;
    logic [2*Y_W+VAR_W-1:0]    trial_prod;
    logic                      trial_ok;
    logic                      aborting;

    always_comb begin
        lane    = '0;
        lane_sq = '0;
        row_sum = '0;
        row_sq  = '0;
        row_cnt = '0;
        for (int unsigned i = 0; i < DESIGN_SIZE; i++) begin
            lane    = bus.inp_data[i*DWIDTH +: DWIDTH];
            lane_sq = (2*DWIDTH)'(lane) * (2*DWIDTH)'(lane);
            if (bus.validity_mask[i]) begin
                row_sum = row_sum + SUM_W'(lane);
                row_sq  = row_sq + SQ_W'($unsigned(lane_sq));
                row_cnt = row_cnt + CNT_W'(1);
            end
        end
    end

    // Mean is divided as 2*|sum|/cnt so the LSB of the quotient carries the rounding half
    always_comb begin
        sum_mag  = sum_q[SUM_W-1] ? SUM_W'(-sum_q) : SUM_W'(sum_q);
        mean_div = DIV_W'({sum_mag, 1'b0});
        mean_mag = DWIDTH'((div_quo[DWIDTH:0] + (DWIDTH+1)'(1)) >> 1);
        mean_new = sum_q[SUM_W-1] ? DWIDTH'(-mean_mag) : mean_mag;
    end

    always_comb begin
        mean_sq  = (2*DWIDTH)'($signed(mean_w_q)) * (2*DWIDTH)'($signed(mean_w_q));
        var_diff = $signed({1'b0, ex2_q}) - (SQ_W+1)'(mean_sq);
        if (var_diff[SQ_W]) begin
            var_clamped = '0;
        end else if (|var_diff[SQ_W-1:VAR_W]) begin
            var_clamped = '1;
        end else begin
            var_clamped = var_diff[VAR_W-1:0];
        end
    end

    always_comb begin
        trial_y    = y_q | (Y_W'(1) << bit_q);
        trial_sq   = (2*Y_W)'(trial_y) * (2*Y_W)'(trial_y);
        trial_prod = (2*Y_W+VAR_W)'(trial_sq) * (2*Y_W+VAR_W)'(var_q);
        trial_ok   = trial_prod <= (2*Y_W+VAR_W)'(RSQRT_NUM);
    end

    assign aborting  = !bus.enable_stats &&
                       (state_q inside {ST_ACCUM, ST_DIV_MEAN, ST_DIV_SQ, ST_VAR, ST_RSQRT});
    assign div_abort = (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        sumsq_d      = sumsq_q;
        cnt_d        = cnt_q;
        rows_d       = rows_q;
        nrows_d      = nrows_q;
        mean_w_d     = mean_w_q;
        ex2_d        = ex2_q;
        var_d        = var_q;
        y_d          = y_q;
        bit_d        = bit_q;
        mean_d       = mean_q;
        inv_d        = inv_q;
        div_start    = 1'b0;
        div_dividend = sumsq_q;
        if (aborting) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.enable_stats) begin
                        sum_d   = '0;
                        sumsq_d = '0;
                        cnt_d   = '0;
                        rows_d  = '0;
                        nrows_d = bus.num_rows;
                        state_d = (bus.num_rows == '0) ? ST_DIV_MEAN : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (bus.in_data_available) begin
                        sum_d   = sum_q + row_sum;
                        sumsq_d = sumsq_q + row_sq;
                        cnt_d   = cnt_q + row_cnt;
                        rows_d  = rows_q + ROWS_W'(1);
                        if (rows_d == nrows_q) begin
                            state_d = ST_DIV_MEAN;
                        end
                    end
                end
                // Second division is launched on the edge the first completes
                ST_DIV_MEAN: begin
                    if (cnt_q == '0) begin
                        mean_d  = '0;
                        inv_d   = INV_SAT;
                        state_d = ST_DONE;
                    end else if (div_done) begin
                        mean_w_d  = mean_new;
                        div_start = 1'b1;
                        state_d   = ST_DIV_SQ;
                    end else if (!div_busy) begin
                        div_start    = 1'b1;
                        div_dividend = mean_div;
                    end
                end
                ST_DIV_SQ: begin
                    if (div_done) begin
                        ex2_d   = div_quo;
                        state_d = ST_VAR;
                    end
                end
                ST_VAR: begin
                    var_d   = var_clamped;
                    y_d     = '0;
                    bit_d   = 3'(Y_W - 1);
                    state_d = ST_RSQRT;
                end
                ST_RSQRT: begin
                    if (trial_ok) begin
                        y_d = trial_y;
                    end
                    bit_d = bit_q - 3'd1;
                    if (bit_q == '0) begin
                        mean_d  = mean_w_q;
                        inv_d   = {1'b0, y_d};
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.enable_stats) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            sumsq_q  <= '0;
            cnt_q    <= '0;
            rows_q   <= '0;
            nrows_q  <= '0;
            mean_w_q <= '0;
            ex2_q    <= '0;
            var_q    <= '0;
            y_q      <= '0;
            bit_q    <= '0;
            mean_q   <= '0;
            inv_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            sumsq_q  <= sumsq_d;
            cnt_q    <= cnt_d;
            rows_q   <= rows_d;
            nrows_q  <= nrows_d;
            mean_w_q <= mean_w_d;
            ex2_q    <= ex2_d;
            var_q    <= var_d;
            y_q      <= y_d;
            bit_q    <= bit_d;
            mean_q   <= mean_d;
            inv_q    <= inv_d;
            valid_q  <= (state_d == ST_DONE);
            done_q   <= (state_d == ST_DONE) && (state_q != ST_DONE);
            busy_q   <= !(state_d inside {ST_IDLE, ST_DONE});
        end
    end

    norm_stats_div u_div (
        .clk        (clk),
        .reset      (reset),
        .abort_i    (div_abort),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (cnt_q),
        .quotient_o (div_quo),
        .busy_o     (div_busy),
        .done_o     (div_done)
    );

    assign bus.mean        = mean_q;
    assign bus.inv_var     = inv_q;
    assign bus.stats_valid = valid_q;
    assign bus.done_stats  = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_norm_stats.sv
// Directed bench for norm_stats: hand-computed mean/inv_var, latency, abort and reset cases.
`timescale 1ns/1ps
module tb_norm_stats;
    import norm_stats_pkg::*;

    logic clk;
    logic reset;
    norm_stats_if bus_if();

    norm_stats dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DESIGN_SIZE*DWIDTH-1:0] fill(input logic [7:0] lo, input logic [7:0] hi);
        logic [DESIGN_SIZE*DWIDTH-1:0] r;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            r[i*DWIDTH +: DWIDTH] = (i < 16) ? lo : hi;
        end
        return r;
    endfunction

    function automatic logic [DESIGN_SIZE*DWIDTH-1:0] ramp();
        logic [DESIGN_SIZE*DWIDTH-1:0] r;
        for (int i = 0; i < DESIGN_SIZE; i++) begin
            r[i*DWIDTH +: DWIDTH] = 8'(i - 18);
        end
        return r;
    endfunction

    task automatic start_pass(input logic [4:0] n);
        bus_if.enable_stats = 1'b1;
        bus_if.num_rows     = n;
        @(negedge clk);
    endtask

    task automatic send_row(input logic [DESIGN_SIZE*DWIDTH-1:0] d, input logic [31:0] m);
        bus_if.in_data_available = 1'b1;
        bus_if.inp_data          = d;
        bus_if.validity_mask     = m;
        @(negedge clk);
        bus_if.in_data_available = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int unsigned n);
        n = 0;
        while (!bus_if.stats_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus_if.stats_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] m, input logic [7:0] iv);
        check({tag, "_mean"}, 32'(bus_if.mean), 32'(m));
        check({tag, "_inv"}, 32'(bus_if.inv_var), 32'(iv));
    endtask

    task automatic end_pass(input string tag);
        bus_if.enable_stats = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(bus_if.stats_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                    = 1'b0;
        bus_if.enable_stats      = 1'b0;
        bus_if.num_rows          = '0;
        bus_if.in_data_available = 1'b0;
        bus_if.inp_data          = '0;
        bus_if.validity_mask     = '0;
        repeat (2) @(negedge clk);
        check("rst_mean", 32'(bus_if.mean), 32'd0);
        check("rst_inv", 32'(bus_if.inv_var), 32'd0);
        check("rst_valid", 32'(bus_if.stats_valid), 32'd0);
        check("rst_done", 32'(bus_if.done_stats), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1 row of 1.0: mean 1.0, zero variance saturates inv_var
        start_pass(5'd1);
        check("c1_busy", 32'(bus_if.busy), 32'd1);
        send_row(fill(8'h08, 8'h08), 32'hFFFF_FFFF);
        wait_valid("c1", edges);
        check("c1_latency", edges, 32'd57);
        check_result("c1", 8'h08, 8'h7F);
        check("c1_done_pulse", 32'(bus_if.done_stats), 32'd1);
        bus_if.in_data_available = 1'b1;
        bus_if.inp_data          = ramp();
        @(negedge clk);
        check("c1_done_clear", 32'(bus_if.done_stats), 32'd0);
        repeat (3) @(negedge clk);
        bus_if.in_data_available = 1'b0;
        check("c1_hold_valid", 32'(bus_if.stats_valid), 32'd1);
        check("c1_hold_busy", 32'(bus_if.busy), 32'd0);
        check_result("c1_hold", 8'h08, 8'h7F);
        end_pass("c1");

        // +2.0 / -2.0 halves: mean 0, var 256 -> inv_var 0.5
        start_pass(5'd1);
        send_row(fill(8'h10, 8'hF0), 32'hFFFF_FFFF);
        wait_valid("c2", edges);
        check_result("c2", 8'h00, 8'h04);
        end_pass("c2");

        // ramp -18..13: sum -80, mean -3, ex2 91, var 82 -> 7
        start_pass(5'd1);
        send_row(ramp(), 32'hFFFF_FFFF);
        wait_valid("c3", edges);
        check("c3_latency", edges, 32'd57);
        check_result("c3", 8'hFD, 8'h07);
        end_pass("c3");

        // all lanes masked off
        start_pass(5'd2);
        send_row(ramp(), 32'h0);
        send_row(fill(8'h10, 8'h10), 32'h0);
        wait_valid("c5a", edges);
        check("c5a_fast", 32'(edges <= 4), 32'd1);
        check_result("c5a", 8'h00, 8'h7F);
        end_pass("c5a");

        // 4 rows with gaps, upper lanes masked out
        start_pass(5'd4);
        for (int r = 0; r < 4; r++) begin
            send_row(fill(8'h10, 8'h7F), 32'h0000_FFFF);
            if (r < 3) repeat (2) @(negedge clk);
        end
        wait_valid("c4", edges);
        check("c4_latency", edges, 32'd57);
        check_result("c4", 8'h10, 8'h7F);
        end_pass("c4");

        // abort inside DIV_SQ keeps previous results
        start_pass(5'd1);
        send_row(ramp(), 32'hFFFF_FFFF);
        repeat (30) @(negedge clk);
        check("ab_busy", 32'(bus_if.busy), 32'd1);
        bus_if.enable_stats = 1'b0;
        @(negedge clk);
        check("ab_idle", 32'(bus_if.busy), 32'd0);
        repeat (60) @(negedge clk);
        check("ab_valid", 32'(bus_if.stats_valid), 32'd0);
        check_result("ab", 8'h10, 8'h7F);

        // num_rows == 0
        start_pass(5'd0);
        wait_valid("c5b", edges);
        check_result("c5b", 8'h00, 8'h7F);
        end_pass("c5b");

        // reset during RSQRT
        start_pass(5'd1);
        send_row(fill(8'h10, 8'hF0), 32'hFFFF_FFFF);
        repeat (52) @(negedge clk);
        check("rs_busy", 32'(bus_if.busy), 32'd1);
        reset               = 1'b0;
        bus_if.enable_stats = 1'b0;
        @(negedge clk);
        check("rs_idle", 32'(bus_if.busy), 32'd0);
        check("rs_valid", 32'(bus_if.stats_valid), 32'd0);
        check_result("rs", 8'h00, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        // ramp again after reset
        start_pass(5'd1);
        send_row(ramp(), 32'hFFFF_FFFF);
        wait_valid("c6", edges);
        check("c6_latency", edges, 32'd57);
        check_result("c6", 8'hFD, 8'h07);
        end_pass("c6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
